data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-lane data memory controller with a single request/response port.
// Stores DEPTH_WORDS 32-bit words. Supports byte, half and word loads and stores,
// with optional sign extension on loads.
// Optional build macro DMEM_MISALIGN_SPLIT_EN:
//   - defined:   misaligned accesses are serviced, and word-crossing ones take an extra SPLIT cycle.
//   - undefined: misaligned accesses are rejected with misalign_err.
module data_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              data_i,
  input  logic              data_o,
  input  logic [1:0]        data_width,
  input  logic              signext,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       input_data,
  output logic [31:0]       read,
  output logic              resp_valid,
  output logic              misalign_err,
  output logic              range_err
);

  localparam int              IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH_WORDS);

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH_WORDS];

  // Load formatting: keep the low byte/half and extend it; a word passes through unchanged.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] width,
                                         input logic sx);
    logic [31:0] res;
    case (width)
      2'b00:   res = {{24{sx & raw[7]}}, raw[7:0]};
      2'b01:   res = {{16{sx & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Request decode
  logic [1:0]       lane;
  logic [ADDR_W:0]  word_ext, word_next;
  logic [IDX_W-1:0] idx_lo, idx_hi;
  logic [7:0]       mask_base, byte_mask;   // lanes of the word pair {word+1, word}
  logic [63:0]      wdata64;
  logic             reserved, misalign_fail, split_need, range_bad;
  logic             is_op, accept, go_ok, err_mis;
  logic [31:0]      rd_single, rd_split;

  // Split-access buffers: captured at acceptance, consumed in SPLIT
  logic [IDX_W-1:0] sp_idx_lo, sp_idx_hi;
  logic [31:0]      sp_rd_lo, sp_wd_lo, sp_wd_hi;
  logic [3:0]       sp_wm_lo, sp_wm_hi;
  logic [1:0]       sp_lane, sp_width;
  logic             sp_sx, sp_write;

  // Memory write ports
  logic             we_lo, we_hi;
  logic [IDX_W-1:0] wi_lo, wi_hi;
  logic [31:0]      wd_lo, wd_hi;
  logic [3:0]       wm_lo, wm_hi;

  assign lane      = data_addr[1:0];
  assign word_ext  = {3'b000, data_addr[ADDR_W-1:2]};
  assign word_next = word_ext + (ADDR_W+1)'(1);
  assign idx_lo    = data_addr[IDX_W+1:2];
  assign idx_hi    = idx_lo + IDX_W'(1);
  assign reserved  = (data_width == 2'b11);
  assign byte_mask = mask_base << lane;
  assign wdata64   = {32'h0000_0000, input_data} << {lane, 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign misalign_fail = 1'b0;
  assign split_need    = ~reserved & (|byte_mask[7:4]);
`else
  assign misalign_fail = ((data_width == 2'b01) & data_addr[0]) |
                         ((data_width == 2'b10) & (lane != 2'b00));
  assign split_need    = 1'b0;
`endif

  // Both words of a crossing access must be in range, otherwise nothing is touched.
  assign range_bad = (word_ext >= DEPTH_LIM) | (split_need & (word_next >= DEPTH_LIM));
  assign is_op     = data_i | data_o;
  assign accept    = req_valid & req_ready;
  assign err_mis   = reserved | misalign_fail;
  assign go_ok     = accept & is_op & ~err_mis & ~range_bad;

  assign rd_single = extend(mem[idx_lo] >> {lane, 3'b000}, data_width, signext);
  assign rd_split  = extend(32'({mem[sp_idx_hi], sp_rd_lo} >> {sp_lane, 3'b000}),
                            sp_width, sp_sx);

  // Base lane mask for the access size; reserved sizes touch no lanes.
  always_comb begin
    mask_base = 8'h00;
    case (data_width)
      2'b00:   mask_base = 8'h01;
      2'b01:   mask_base = 8'h03;
      2'b10:   mask_base = 8'h0F;
      default: mask_base = 8'h00;
    endcase
  end

  // Select the write port sources: a direct store in IDLE, or both halves of a split store in SPLIT.
  always_comb begin
    we_lo = 1'b0;
    we_hi = 1'b0;
    wi_lo = idx_lo;
    wi_hi = sp_idx_hi;
    wd_lo = wdata64[31:0];
    wd_hi = sp_wd_hi;
    wm_lo = byte_mask[3:0];
    wm_hi = sp_wm_hi;
    if (state == SPLIT) begin
      we_lo = sp_write;
      we_hi = sp_write;
      wi_lo = sp_idx_lo;
      wd_lo = sp_wd_lo;
      wm_lo = sp_wm_lo;
    end else begin
      we_lo = go_ok & ~split_need & data_i;
    end
  end

  // Byte-lane memory writes; contents are intentionally not reset.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (we_lo && wm_lo[b]) mem[wi_lo][8*b +: 8] <= wd_lo[8*b +: 8];
      if (we_hi && wm_hi[b]) mem[wi_hi][8*b +: 8] <= wd_hi[8*b +: 8];
    end
  end

  // Next-state logic: only an accepted, legal, word-crossing access enters SPLIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (go_ok && split_need) state_next = SPLIT;
        else                     state_next = IDLE;
      end
      SPLIT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any pending split access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Capture everything the second cycle of a split access needs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp_idx_lo <= '0;
      sp_idx_hi <= '0;
      sp_rd_lo  <= 32'h0000_0000;
      sp_wd_lo  <= 32'h0000_0000;
      sp_wd_hi  <= 32'h0000_0000;
      sp_wm_lo  <= 4'h0;
      sp_wm_hi  <= 4'h0;
      sp_lane   <= 2'b00;
      sp_width  <= 2'b00;
      sp_sx     <= 1'b0;
      sp_write  <= 1'b0;
    end else if (go_ok && split_need) begin
      sp_idx_lo <= idx_lo;
      sp_idx_hi <= idx_hi;
      sp_rd_lo  <= mem[idx_lo];
      sp_wd_lo  <= wdata64[31:0];
      sp_wd_hi  <= wdata64[63:32];
      sp_wm_lo  <= byte_mask[3:0];
      sp_wm_hi  <= byte_mask[7:4];
      sp_lane   <= lane;
      sp_width  <= data_width;
      sp_sx     <= signext;
      sp_write  <= data_i;
    end
  end

  // Registered response: one-cycle pulse with flags; read holds between responses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
      read         <= 32'h0000_0000;
    end else begin
      req_ready    <= (state_next == IDLE);
      resp_valid   <= 1'b0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
      if (state == SPLIT) begin
        resp_valid <= 1'b1;
        read       <= sp_write ? 32'h0000_0000 : rd_split;
      end else if (accept && is_op && !(go_ok && split_need)) begin
        resp_valid   <= 1'b1;
        misalign_err <= err_mis;
        range_err    <= range_bad;
        read         <= (data_i || !go_ok) ? 32'h0000_0000 : rd_single;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl. A byte-array reference model predicts every output on every
// cycle; a few literal expectations pin known results. It also builds with DMEM_MISALIGN_SPLIT_EN.
module tb_data_mem_ctrl;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2048;

  logic        CLK, RST, req_valid, data_i, data_o, signext;
  logic [1:0]  data_width;
  logic [31:0] data_addr, input_data;
  logic        req_ready, resp_valid, misalign_err, range_err;
  logic [31:0] read;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  mm [DEPTH*4];
  bit          m_ready, m_valid, m_mis, m_rng;
  logic [31:0] m_read;
  bit          p_pend, p_wr, p_sx;
  int          p_addr, p_n;
  logic [31:0] p_data;

  data_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .data_i(data_i), .data_o(data_o), .data_width(data_width), .signext(signext),
    .data_addr(data_addr), .input_data(input_data), .read(read),
    .resp_valid(resp_valid), .misalign_err(misalign_err), .range_err(range_err)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%08h expected=%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wbytes(input logic [1:0] w);
    case (w)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  // Little-endian load of n bytes from the model memory, then extension.
  function automatic logic [31:0] load(input int a, input int n, input bit sx);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | ({24'h0, mm[a+i]} << (8*i));
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic model_reset();
    m_ready = 1'b0; m_valid = 1'b0; m_mis = 1'b0; m_rng = 1'b0;
    m_read  = 32'h0; p_pend = 1'b0;
  endtask

  // Model of one rising edge, evaluated with the inputs present at that edge.
  task automatic model_edge();
    int a, n;
    bit crosses, misfail, rng;
    m_valid = 1'b0; m_mis = 1'b0; m_rng = 1'b0;
    if (p_pend) begin
      p_pend  = 1'b0;
      m_valid = 1'b1;
      if (p_wr) begin
        for (int i = 0; i < p_n; i++) mm[p_addr+i] = p_data[8*i +: 8];
        m_read = 32'h0;
      end else begin
        m_read = load(p_addr, p_n, p_sx);
      end
    end else if (req_valid && m_ready && (data_i || data_o)) begin
      a       = int'(data_addr);
      n       = wbytes(data_width);
      crosses = ((a % 4) + n) > 4;
`ifdef DMEM_MISALIGN_SPLIT_EN
      misfail = (n == 0);
      rng     = (a / 4 >= DEPTH) || (!misfail && crosses && ((a + n - 1) / 4 >= DEPTH));
`else
      misfail = (n == 0) || (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
      rng     = (a / 4 >= DEPTH);
`endif
      if (misfail || rng) begin
        m_valid = 1'b1; m_mis = misfail; m_rng = rng; m_read = 32'h0;
      end else if (crosses) begin
        p_pend = 1'b1; p_wr = data_i; p_addr = a; p_n = n; p_sx = signext; p_data = input_data;
      end else begin
        m_valid = 1'b1;
        if (data_i) begin
          for (int i = 0; i < n; i++) mm[a+i] = input_data[8*i +: 8];
          m_read = 32'h0;
        end else begin
          m_read = load(a, n, signext);
        end
      end
    end
    m_ready = !p_pend;
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge CLK) begin
    chk("req_ready",    {31'b0, req_ready},    {31'b0, m_ready});
    chk("resp_valid",   {31'b0, resp_valid},   {31'b0, m_valid});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    chk("range_err",    {31'b0, range_err},    {31'b0, m_rng});
    chk("read",         read,                  m_read);
  end

  task automatic tick();
    @(posedge CLK);
    if (!RST) model_edge();
    #1;
  endtask

  task automatic req(input bit wr, input bit rd, input logic [1:0] w, input bit sx,
                     input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; data_i = wr; data_o = rd; data_width = w;
    signext = sx; data_addr = a; input_data = d;
    tick();
    req_valid = 1'b0; data_i = 1'b0; data_o = 1'b0;
  endtask

  // Literal expectation on a response cycle, pinned on both the DUT and the model.
  task automatic lit(input string nm, input logic [31:0] exp);
    chk({nm, "_valid"}, {31'b0, resp_valid}, 32'h1);
    chk(nm, read, exp);
    chk({nm, "_model"}, m_read, exp);
  endtask

  initial begin
    RST = 1'b1; req_valid = 1'b0; data_i = 1'b0; data_o = 1'b0; signext = 1'b0;
    data_width = 2'b00; data_addr = 32'h0; input_data = 32'h0;
    model_reset();
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("ready_after_reset", {31'b0, req_ready}, 32'h1);

    // Byte write then read back.
    req(1, 0, 2'b00, 0, 32'd5, 32'h0000_0002);
    req(0, 1, 2'b00, 0, 32'd5, 32'h0);
    lit("byte_rd_5", 32'h0000_0002);

    // Word write, then sign-extended byte and zero-extended half.
    req(1, 0, 2'b10, 0, 32'd8, 32'h8000_80F0);
    req(0, 1, 2'b00, 1, 32'd8, 32'h0);
    lit("byte_sx_8", 32'hFFFF_FFF0);
    req(0, 1, 2'b01, 0, 32'd10, 32'h0);
    lit("half_zx_10", 32'h0000_8000);

    // Back-to-back write then read on consecutive cycles.
    req(1, 0, 2'b10, 0, 32'd12, 32'h1111_1111);
    req(1, 0, 2'b10, 0, 32'd12, 32'hDEAD_BEEF);
    req(0, 1, 2'b10, 0, 32'd12, 32'h0);
    lit("b2b_rd_12", 32'hDEAD_BEEF);

    // Lane writes and extension variants.
    req(1, 0, 2'b10, 0, 32'h20, 32'h1234_5678);
    req(1, 0, 2'b01, 0, 32'h22, 32'h0000_A5C3);
    req(0, 1, 2'b01, 1, 32'h22, 32'h0);
    lit("half_sx_22", 32'hFFFF_A5C3);
    req(0, 1, 2'b00, 0, 32'h23, 32'h0);
    req(0, 1, 2'b00, 1, 32'h23, 32'h0);
    req(0, 1, 2'b10, 0, 32'h20, 32'h0);
    lit("word_rd_20", 32'hA5C3_5678);
    for (int i = 0; i < 4; i++) req(1, 0, 2'b00, 0, 32'h30 + i, 32'(8'h11 * (i + 1)));
    req(0, 1, 2'b10, 0, 32'h30, 32'h0);
    lit("lanes_rd_30", 32'h4433_2211);

    // Both strobes means write; neither means discard.
    req(1, 1, 2'b10, 0, 32'h40, 32'h600D_CAFE);
    req(0, 0, 2'b10, 0, 32'h40, 32'h0);
    tick();
    req(0, 1, 2'b10, 0, 32'h40, 32'h0);
    lit("both_rd_40", 32'h600D_CAFE);

    // Reserved size: error, no memory change.
    req(1, 0, 2'b11, 0, 32'h30, 32'hFFFF_FFFF);
    req(0, 1, 2'b11, 0, 32'h30, 32'h0);
    req(0, 1, 2'b10, 0, 32'h30, 32'h0);

    // Misaligned within-word and crossing accesses.
    req(0, 1, 2'b01, 1, 32'h21, 32'h0);
    req(1, 0, 2'b10, 0, 32'h1000, 32'h4433_2211);
    req(1, 0, 2'b10, 0, 32'h1004, 32'h8877_6655);
    req(0, 1, 2'b10, 0, 32'h1001, 32'h0);
`ifdef DMEM_MISALIGN_SPLIT_EN
    chk("split_ready_low", {31'b0, req_ready}, 32'h0);
    tick();
    lit("split_rd_1001", 32'h5544_3322);
`else
    chk("mis_1001_flag", {31'b0, misalign_err}, 32'h1);
    lit("mis_rd_1001", 32'h0);
`endif
    req(0, 1, 2'b01, 1, 32'h1003, 32'h0);
    tick();
    req(1, 0, 2'b10, 0, 32'h50, 32'h0102_0304);
    req(1, 0, 2'b10, 0, 32'h54, 32'h0506_0708);
    req(1, 0, 2'b10, 0, 32'h53, 32'hA1B2_C3D4);
    tick();
    req(0, 1, 2'b10, 0, 32'h50, 32'h0);
    req(0, 1, 2'b10, 0, 32'h54, 32'h0);

    // Range: out-of-range read and write, and a crossing access at the top.
    req(1, 0, 2'b10, 0, 32'h0, 32'h1357_9BDF);
    req(0, 1, 2'b10, 0, DEPTH * 4, 32'h0);
    chk("range_flag", {31'b0, range_err}, 32'h1);
    lit("range_rd", 32'h0);
    req(1, 0, 2'b10, 0, DEPTH * 4, 32'hFFFF_FFFF);
    req(0, 1, 2'b10, 0, 32'h0, 32'h0);
    lit("range_wr_kept", 32'h1357_9BDF);
    req(0, 1, 2'b10, 0, DEPTH * 4 - 2, 32'h0);
    tick();

    // Reset right after accepting a word write at 0x0FFE.
    req(1, 0, 2'b10, 0, 32'hFFC, 32'hCAFE_F00D);
    req(1, 0, 2'b10, 0, 32'hFFE, 32'h1234_5678);
    RST = 1'b1;
    model_reset();
    repeat (2) tick();
    RST = 1'b0;
    tick();
    chk("ready_after_abort", {31'b0, req_ready}, 32'h1);
    req(0, 1, 2'b10, 0, 32'hFFC, 32'h0);
    lit("abort_w3ff", 32'hCAFE_F00D);
    req(0, 1, 2'b10, 0, 32'h1000, 32'h0);
    lit("abort_w400", 32'h4433_2211);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
